// File: rtl/sqrt_pkg.sv
// Shared types and constants for the iterative square-root block.
package sqrt_pkg;

   // Controller states: waiting for an operand, iterating, holding a result.
   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   localparam int unsigned DEFAULT_WIDTH = 16;

   // Iteration counter width: enough to hold WIDTH/2-1, plus one spare bit.
   function automatic int unsigned cnt_width(input int unsigned width);
      return $clog2(width / 2) + 1;
   endfunction

endpackage

// File: rtl/sqrt_step.sv
// One non-restoring square-root iteration: shifts the next radicand pair into the
// signed partial remainder, adds or subtracts the trial term and yields the next root bit.
// With SQRT_ITER_REMAINDER_EN defined, the last iteration also folds in the correction
// that makes a negative final remainder non-negative.
module sqrt_step #(
   parameter int unsigned HALF = 8
) (
   input  logic signed [HALF+1:0] rem,
   input  logic        [HALF-1:0] root,
   input  logic        [1:0]      pair,
`ifdef SQRT_ITER_REMAINDER_EN
   input  logic                   last,
`endif
   output logic signed [HALF+1:0] rem_next,
   output logic        [HALF-1:0] root_next
);

   localparam int unsigned RW = HALF + 2;

   logic [RW-1:0] shifted;
   logic [RW-1:0] trial;
   logic [RW-1:0] raw;
   logic [HALF-1:0] q_next;

   // Add or subtract the trial term depending on the sign of the previous remainder.
   always_comb begin
      shifted = RW'(rem <<< 2) | RW'(pair);
      trial   = {root, (rem[RW-1] ? 2'b11 : 2'b01)};
      if (rem[RW-1]) begin
         raw = shifted + trial;
      end else begin
         raw = shifted - trial;
      end
      // A non-negative new remainder means this root bit is 1.
      q_next    = {root[HALF-2:0], ~raw[RW-1]};
      root_next = q_next;
`ifdef SQRT_ITER_REMAINDER_EN
      if (last && raw[RW-1]) begin
         rem_next = raw + {1'b0, q_next, 1'b1};
      end else begin
         rem_next = raw;
      end
`else
      rem_next = raw;
`endif
   end

endmodule

// File: rtl/sqrt_iter.sv
// Iterative integer square root: floor(sqrt(in_data)) resolved one bit per cycle,
// with valid/ready handshakes on both sides.
// Optional macro SQRT_ITER_REMAINDER_EN adds the out_rem port and the final
// remainder correction.
module sqrt_iter
   import sqrt_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
`ifdef SQRT_ITER_REMAINDER_EN
   output logic [WIDTH/2:0]     out_rem,
`endif
   output logic [WIDTH/2-1:0]   out_root
);

   localparam int unsigned HALF  = WIDTH / 2;
   localparam int unsigned CNT_W = cnt_width(WIDTH);

   state_t state_q, state_d;

   logic        [WIDTH-1:0] rad_q;
   logic        [HALF-1:0]  root_q;
   logic signed [HALF+1:0]  rem_q;
   logic        [CNT_W-1:0] cnt_q;

   logic signed [HALF+1:0]  rem_step;
   logic        [HALF-1:0]  root_step;
   logic                    last;
   logic                    load;

   assign last = (cnt_q == '0);
   assign load = (state_q == IDLE) && in_valid;

   sqrt_step #(
      .HALF(HALF)
   ) u_step (
      .rem      (rem_q),
      .root     (root_q),
      .pair     (rad_q[WIDTH-1 -: 2]),
`ifdef SQRT_ITER_REMAINDER_EN
      .last     (last),
`endif
      .rem_next (rem_step),
      .root_next(root_step)
   );

   // State register; reset wins over any handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and handshake outputs.
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_d = CALC;
            end
         end
         CALC: begin
            if (last) begin
               state_d = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Datapath: capture on input handshake, iterate in CALC, hold otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         rad_q  <= '0;
         root_q <= '0;
         rem_q  <= '0;
         cnt_q  <= '0;
      end else if (load) begin
         rad_q  <= in_data;
         root_q <= '0;
         rem_q  <= '0;
         cnt_q  <= CNT_W'(HALF - 1);
      end else if (state_q == CALC) begin
         rad_q  <= rad_q << 2;
         root_q <= root_step;
         rem_q  <= rem_step;
         if (!last) begin
            cnt_q <= cnt_q - CNT_W'(1);
         end
      end
   end

   assign out_root = root_q;
`ifdef SQRT_ITER_REMAINDER_EN
   assign out_rem  = rem_q[HALF:0];
`endif

endmodule

// File: tb/tb_sqrt_iter.sv
// Scoreboard bench for sqrt_iter (WIDTH=16): directed operands with hand-computed
// roots/remainders, latency, backpressure, reset abort and back-to-back spacing.
module tb_sqrt_iter;

   localparam int unsigned W = 16;
   localparam int unsigned H = W / 2;

   typedef struct {
      logic [H-1:0] root;
      logic [H:0]   rem;
      int           hs;
      int           gap;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [H-1:0] out_root;
`ifdef SQRT_ITER_REMAINDER_EN
   logic [H:0]   out_rem;
`endif

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   cycle = 0;
   int   valid_cycle = 0;
   int   last_valid = 0;
   logic prev_valid = 1'b0;

   sqrt_iter #(
      .WIDTH(W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
`ifdef SQRT_ITER_REMAINDER_EN
      .out_rem  (out_rem),
`endif
      .out_root (out_root)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;

   task automatic check(input string name, input int got, input int want);
      n_cmp++;
      if (got != want) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cycle);
      end
   endtask

   // Offer one operand, wait (bounded) for acceptance and record the expected result.
   task automatic send(input logic [W-1:0] d, input logic [H-1:0] r, input logic [H:0] m,
                       input int gap, output int waited);
      logic ok;
      waited   = 0;
      ok       = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      while (!ok && waited <= 100) begin
         @(negedge clk);
         if (in_ready) ok = 1'b1;
         else waited++;
      end
      if (ok) begin
         sb.push_back('{root: r, rem: m, hs: cycle + 1, gap: gap});
      end else begin
         check("accept_timeout", 0, 1);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = 16'hA5A5;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
      @(posedge clk);
      #1;
   endtask

   // Monitor: pops the scoreboard on every output handshake.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (out_valid && !prev_valid) valid_cycle = cycle;
         prev_valid = out_valid;
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check("spurious_valid", 1, 0);
            end else begin
               e = sb.pop_front();
               check("out_root", int'(out_root), int'(e.root));
`ifdef SQRT_ITER_REMAINDER_EN
               check("out_rem", int'(out_rem), int'(e.rem));
`endif
               // Handshake on edge N, DONE reached on edge N+H.
               check("latency", valid_cycle - e.hs, H);
               if (e.gap >= 0) check("result_spacing", valid_cycle - last_valid, e.gap);
            end
            last_valid = valid_cycle;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   w;
      int   n;
      logic seen;
      logic stable;
      rst       = 1'b1;
      in_valid  = 1'b1;
      in_data   = 16'd144;
      out_ready = 1'b1;

      // Reset state.
      @(negedge clk);
      check("reset_in_ready", int'(in_ready), 1);
      check("reset_out_valid", int'(out_valid), 0);
      check("reset_out_root", int'(out_root), 0);
`ifdef SQRT_ITER_REMAINDER_EN
      check("reset_out_rem", int'(out_rem), 0);
`endif
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // First operand accepted on the first edge after reset release.
      send(16'd144, 8'd12, 9'd0, -1, w);
      check("first_hs_wait", w, 0);
      wait_drain();

      send(16'd65535, 8'd255, 9'd510, -1, w);
      wait_drain();
      send(16'd0, 8'd0, 9'd0, -1, w);
      wait_drain();
      send(16'd8, 8'd2, 9'd4, -1, w);
      wait_drain();

      // Backpressure: result held for 20 cycles, then released on first out_ready.
      out_ready = 1'b0;
      send(16'd15, 8'd3, 9'd6, -1, w);
      n = 0;
      while (!out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("bp_valid_seen", int'(out_valid), 1);
      for (int i = 0; i < 20; i++) begin
         stable = out_valid && !in_ready && (out_root == 8'd3);
`ifdef SQRT_ITER_REMAINDER_EN
         stable = stable && (out_rem == 9'd6);
`endif
         check("bp_hold", int'(stable), 1);
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("bp_release_valid", int'(out_valid), 0);
      check("bp_release_ready", int'(in_ready), 1);
      wait_drain();

      // Back-to-back with in_valid and out_ready held high: results 10 cycles apart.
      send(16'd1, 8'd1, 9'd0, -1, w);
      send(16'd2, 8'd1, 9'd1, 10, w);
      send(16'd255, 8'd15, 9'd30, 10, w);
      send(16'd256, 8'd16, 9'd0, 10, w);
      send(16'd50000, 8'd223, 9'd271, 10, w);
      wait_drain();

      // Reset during CALC cycle 4 aborts the operation.
      send(16'd1000, 8'd31, 9'd39, -1, w);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      if (sb.size() != 0) void'(sb.pop_back());
      @(negedge clk);
      check("abort_in_ready", int'(in_ready), 1);
      check("abort_out_valid", int'(out_valid), 0);
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      check("abort_no_valid", int'(seen), 0);
      @(posedge clk);
      #1;
      send(16'd81, 8'd9, 9'd0, -1, w);
      wait_drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
